// File: rtl/ps2_pkg.sv
// ps2_pkg: PS/2 scan-code prefixes, decoder states and key-event field layout
package ps2_pkg;
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;
  localparam int PAUSE_TAIL = 7;
  localparam int EVT_W = 10;
  localparam int EVT_BRK = 9;
  localparam int EVT_EXT = 8;
  typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_SKIP} dec_state_t;
  function automatic logic [EVT_W-1:0] mk_evt(input logic brk, input logic ext, input logic [7:0] code);
    return {brk, ext, code};
  endfunction
endpackage

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo: synchronous event FIFO; head reads zero while empty
module ps2_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic wr, rd;
  assign rd = pop & ~empty;
  // a push into a full queue is accepted when a pop frees the slot in the same cycle
  assign wr = push & (~full | rd);
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign head = empty ? '0 : mem[rp];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (wr) mem[wp] <= din;
      wp <= wr ? wp + 1'b1 : wp;
      rp <= rd ? rp + 1'b1 : rp;
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/ps2_key_event.sv
// ps2_key_event: PS/2 receiver with frame check, scan-code decoder, repeat filter and event FIFO
module ps2_key_event import ps2_pkg::*; #(
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             iCLK_50,
  input  logic             iRST,
  input  logic             iPS2_CLK,
  input  logic             iPS2_DAT,
  output logic             oEVT_VALID,
  output logic [EVT_W-1:0] oEVT_DATA,
  input  logic             iEVT_READY,
  output logic [7:0]       oLAST_MAKE,
  output logic             oFRAME_ERR,
  output logic             oOVERFLOW
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [1:0] kc_s, kd_s;
  logic kc_q, kd_q, fall;
  logic [3:0] bit_cnt;
  logic [9:0] sr;
  logic [TW-1:0] idle;
  logic last, good, tmo, byte_rdy;
  logic [7:0] rx;
  dec_state_t st;
  logic ext;
  logic [2:0] skip;
  logic evt_v;
  logic [EVT_W-1:0] evt;
  logic held_v;
  logic [EVT_EXT:0] held;
  logic is_make, match, emit, pop, full, empty;
  always_ff @(posedge iCLK_50) begin
    if (iRST) begin
      kc_s <= 2'b11;
      kd_s <= 2'b11;
      kc_q <= 1'b1;
      kd_q <= 1'b1;
      fall <= 1'b0;
    end else begin
      kc_s <= {kc_s[0], iPS2_CLK};
      kd_s <= {kd_s[0], iPS2_DAT};
      kc_q <= kc_s[1];
      kd_q <= kd_s[1];
      fall <= kc_q & ~kc_s[1];
    end
  end
  // sr holds bits 0..9 once ten edges are in; the stop bit is judged live from kd_q
  assign last = fall & (bit_cnt == 4'd10);
  assign good = ~sr[0] & kd_q & ^sr[9:1];
  assign tmo = (bit_cnt != '0) && !fall && (idle == TW'(TIMEOUT_CYC - 1));
  always_ff @(posedge iCLK_50) begin
    if (iRST) begin
      bit_cnt <= '0;
      sr <= '0;
      idle <= '0;
      byte_rdy <= 1'b0;
      rx <= '0;
      oFRAME_ERR <= 1'b0;
    end else begin
      byte_rdy <= last & good;
      oFRAME_ERR <= (last & ~good) | tmo;
      rx <= last ? sr[8:1] : rx;
      sr <= fall ? {kd_q, sr[9:1]} : sr;
      bit_cnt <= (tmo || last) ? '0 : fall ? bit_cnt + 4'd1 : bit_cnt;
      idle <= (fall || bit_cnt == '0 || tmo) ? '0 : idle + 1'b1;
    end
  end
  always_ff @(posedge iCLK_50) begin
    if (iRST) begin
      st <= ST_IDLE;
      ext <= 1'b0;
      skip <= '0;
      evt_v <= 1'b0;
      evt <= '0;
    end else begin
      evt_v <= 1'b0;
      if (oFRAME_ERR) st <= ST_IDLE;
      else if (byte_rdy)
        case (st)
          ST_IDLE:
            if (rx == PS2_EXT) st <= ST_EXT;
            else if (rx == PS2_BRK) begin
              st <= ST_BRK;
              ext <= 1'b0;
            end else if (rx == PS2_PAUSE) begin
              st <= ST_SKIP;
              skip <= 3'(PAUSE_TAIL);
            end else begin
              evt_v <= 1'b1;
              evt <= mk_evt(1'b0, 1'b0, rx);
            end
          ST_EXT:
            if (rx == PS2_BRK) begin
              st <= ST_BRK;
              ext <= 1'b1;
            end else begin
              st <= ST_IDLE;
              evt_v <= 1'b1;
              evt <= mk_evt(1'b0, 1'b1, rx);
            end
          ST_BRK: begin
            st <= ST_IDLE;
            evt_v <= 1'b1;
            evt <= mk_evt(1'b1, ext, rx);
          end
          default: begin
            skip <= skip - 3'd1;
            st <= (skip == 3'd1) ? ST_IDLE : ST_SKIP;
          end
        endcase
    end
  end
  // a make equal to the held key is a typematic repeat and never reaches the queue
  assign is_make = ~evt[EVT_BRK];
  assign match = held_v && held == evt[EVT_EXT:0];
  assign emit = evt_v & ~(is_make & match);
  assign pop = oEVT_VALID & iEVT_READY;
  assign oEVT_VALID = ~empty;
  always_ff @(posedge iCLK_50) begin
    if (iRST) begin
      held_v <= 1'b0;
      held <= '0;
      oLAST_MAKE <= '0;
      oOVERFLOW <= 1'b0;
    end else begin
      if (emit & is_make) begin
        held_v <= 1'b1;
        held <= evt[EVT_EXT:0];
        oLAST_MAKE <= evt[7:0];
      end else if (evt_v & ~is_make & match) held_v <= 1'b0;
      oOVERFLOW <= oOVERFLOW | (emit & full & ~pop);
    end
  end
  ps2_evt_fifo #(.DEPTH(FIFO_DEPTH), .W(EVT_W)) u_fifo (
    .clk(iCLK_50),
    .rst(iRST),
    .push(emit),
    .pop(pop),
    .din(evt),
    .head(oEVT_DATA),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_ps2_key_event.sv
// tb_ps2_key_event: drives PS/2 frames and checks key events against a scoreboard queue
module tb_ps2_key_event;
  localparam int H = 10;
  localparam int TMO = 50000;
  logic clk = 1'b0, rst = 1'b1, kc = 1'b1, kd = 1'b1, ready = 1'b1;
  logic valid, fe, ovf;
  logic [9:0] data;
  logic [7:0] last;
  int n_cmp = 0, n_bad = 0, fe_cnt = 0, f0;
  logic [31:0] sb[$];
  logic [31:0] e;
  event stop_ev;
  always #5 clk = ~clk;
  ps2_key_event dut (
    .iCLK_50(clk), .iRST(rst), .iPS2_CLK(kc), .iPS2_DAT(kd),
    .oEVT_VALID(valid), .oEVT_DATA(data), .iEVT_READY(ready),
    .oLAST_MAKE(last), .oFRAME_ERR(fe), .oOVERFLOW(ovf)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    #1;
    if (fe) fe_cnt++;
    if (valid && ready) begin
      e = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD;
      chk("evt", {22'd0, data}, e);
    end
  end
  task automatic send_frame(input logic [7:0] b, input logic par_ok, input logic stop, input int nbits);
    logic [10:0] f;
    f = {stop, (~^b) ^ ~par_ok, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk) kd = f[i];
      repeat (H) @(negedge clk);
      kc = 1'b0;
      if (i == 10) -> stop_ev;
      repeat (H) @(negedge clk);
      kc = 1'b1;
    end
    kd = 1'b1;
  endtask
  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b1, 1'b1, 11);
  endtask
  task automatic expect_evt(input logic [9:0] v);
    sb.push_back({22'd0, v});
  endtask
  task automatic drain(input string tag);
    repeat (30) @(negedge clk);
    chk(tag, sb.size(), 0);
  endtask
  task automatic chk_zero(input string tag);
    #1;
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_data"}, data, 0);
    chk({tag, "_last"}, last, 0);
    chk({tag, "_ferr"}, fe, 0);
    chk({tag, "_ovf"}, ovf, 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (4) @(negedge clk);
    chk_zero("rst");
    @(negedge clk) rst = 1'b0;
    expect_evt(10'h01C);
    expect_evt(10'h21C);
    fork
      send(8'h1C);
      begin
        @(stop_ev);
        repeat (5) @(negedge clk);
        #1 chk("lat_n2", valid, 0);
        @(negedge clk);
        #1 chk("lat_n3", valid, 1);
      end
    join
    chk("last_1c", last, 8'h1C);
    send(8'hF0);
    send(8'h1C);
    drain("mk_brk");
    expect_evt(10'h01C);
    expect_evt(10'h21C);
    repeat (5) send(8'h1C);
    send(8'hF0);
    send(8'h1C);
    drain("typematic");
    expect_evt(10'h175);
    expect_evt(10'h375);
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    drain("ext");
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    expect_evt(10'h029);
    send(8'h29);
    drain("pause");
    f0 = fe_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    send_frame(8'h1C, 1'b1, 1'b0, 11);
    drain("bad_none");
    chk("ferr_bad", fe_cnt - f0, 2);
    f0 = fe_cnt;
    send_frame(8'h55, 1'b1, 1'b1, 5);
    repeat (TMO + 100) @(negedge clk);
    chk("ferr_tmo", fe_cnt - f0, 1);
    expect_evt(10'h01B);
    send(8'h1B);
    drain("after_tmo");
    ready = 1'b0;
    for (int i = 0; i < 4; i++) expect_evt(10'h011 + 10'(i));
    for (int i = 0; i < 4; i++) send(8'h11 + 8'(i));
    #1 chk("ovf_pre", ovf, 0);
    send(8'h15);
    send(8'h16);
    #1 chk("ovf_set", ovf, 1);
    chk("head_hold", data, 10'h011);
    chk("full_valid", valid, 1);
    expect_evt(10'h017);
    fork
      send(8'h17);
      begin
        @(stop_ev);
        repeat (5) @(negedge clk);
        ready = 1'b1;
        @(negedge clk) ready = 1'b0;
      end
    join
    #1 chk("pp_head", data, 10'h012);
    chk("last_17", last, 8'h17);
    ready = 1'b1;
    drain("pushpop");
    send_frame(8'h3A, 1'b1, 1'b1, 6);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("midrst");
    rst = 1'b0;
    f0 = fe_cnt;
    expect_evt(10'h01C);
    send(8'h1C);
    drain("post_rst");
    chk("ferr_rst", fe_cnt - f0, 0);
    chk("last_rst", last, 8'h1C);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
